// File: rtl/weight_bias_stream_fetcher_if.sv
`timescale 1ns/1ps
// Weight-BRAM read port plus the weight/bias output stream of the fetcher.
// Latency: none; this file only bundles wires.
// Backpressure: m_ready (slave to master) stalls the stream; the memory port has none.
//
// Ports:
//   mem_en / mem_addr   fetcher -> BRAM, read request
//   mem_rdata           BRAM -> fetcher, data one cycle after mem_en
//   m_valid / m_ready   output beat handshake
//   m_weights, m_bias, m_first, m_last, m_neuron   beat payload and tags
interface weight_bias_stream_fetcher_if #(
  parameter int LANES     = 4,
  parameter int W_PREC    = 8,
  parameter int BIAS_PREC = 32,
  parameter int CHUNKS    = 2,
  parameter int M         = 16
);
  localparam int MEM_W  = LANES * W_PREC + BIAS_PREC;
  localparam int ADDR_W = (M * CHUNKS > 1) ? $clog2(M * CHUNKS) : 1;
  localparam int IDX_W  = (M > 1) ? $clog2(M) : 1;

  logic                    mem_en;
  logic [ADDR_W-1:0]       mem_addr;
  logic [MEM_W-1:0]        mem_rdata;

  logic                    m_valid;
  logic                    m_ready;
  logic [LANES*W_PREC-1:0] m_weights;
  logic [BIAS_PREC-1:0]    m_bias;
  logic                    m_first;
  logic                    m_last;
  logic [IDX_W-1:0]        m_neuron;

  // Fetcher side.
  modport master (
    output mem_en, mem_addr,
    input  mem_rdata,
    output m_valid, m_weights, m_bias, m_first, m_last, m_neuron,
    input  m_ready
  );

  // BRAM / MAC-array side.
  modport slave (
    input  mem_en, mem_addr,
    output mem_rdata,
    input  m_valid, m_weights, m_bias, m_first, m_last, m_neuron,
    output m_ready
  );
endinterface

// File: rtl/weight_bias_stream_fetcher.sv
`timescale 1ns/1ps
// Streams per-neuron weight chunks and the neuron bias from a 1-cycle weight BRAM to the MAC array.
// Latency: start edge -> mem_en next cycle -> m_valid two cycles later; 1 beat/cycle sustained.
// Backpressure: 2-entry output FIFO; reads are issued only when a FIFO slot is guaranteed.
//
// Ports:
//   clk, clr           clock, asynchronous active-high reset
//   start              begins a pass (only honoured while idle)
//   num_neurons        neurons per pass, latched on start, clamped to M
//   loop               restart the pass at address 0 when the final beat is accepted
//   bus (master)       BRAM read port and output stream, see weight_bias_stream_fetcher_if
//   busy, done         pass in progress / one-cycle end-of-pass pulse
module weight_bias_stream_fetcher #(
  parameter  int LANES     = 4,
  parameter  int W_PREC    = 8,
  parameter  int BIAS_PREC = 32,
  parameter  int CHUNKS    = 2,
  parameter  int M         = 16,
  localparam int ADDR_W    = (M * CHUNKS > 1) ? $clog2(M * CHUNKS) : 1,
  localparam int IDX_W     = (M > 1) ? $clog2(M) : 1
) (
  input  logic                            clk,
  input  logic                            clr,
  input  logic                            start,
  input  logic [IDX_W:0]                  num_neurons,
  input  logic                            loop,
  weight_bias_stream_fetcher_if.master    bus,
  output logic                            busy,
  output logic                            done
);
  localparam int CHK_W = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam logic [IDX_W:0]   M_CAP    = (IDX_W + 1)'(M);
  localparam logic [CHK_W-1:0] LAST_CHK = CHK_W'(CHUNKS - 1);

  // Bias field sits above the weight lanes in each BRAM word.
  typedef struct packed {
    logic [BIAS_PREC-1:0]    bias;
    logic [LANES*W_PREC-1:0] weights;
  } word_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [IDX_W:0]       count;
  logic [ADDR_W-1:0]    rd_addr;
  logic [ADDR_W-1:0]    last_addr;
  logic                 rd_pend;      // read issued last cycle, data on mem_rdata now
  word_t                fifo_mem [2];
  logic                 wr_ptr;
  logic                 rd_ptr;
  logic [1:0]           occ;
  logic [CHK_W-1:0]     out_chunk;
  logic [IDX_W-1:0]     out_neuron;
  logic [BIAS_PREC-1:0] bias_q;
  logic                 done_q;

  logic                 issue;
  logic                 m_vld;
  logic                 pop;
  logic                 head_first;
  logic                 head_last;
  logic                 final_beat;
  logic [IDX_W:0]       clamped;
  logic [31:0]          pass_words;
  word_t                head;

  assign clamped    = (num_neurons > M_CAP) ? M_CAP : num_neurons;
  assign pass_words = 32'(clamped) * 32'(CHUNKS);

  assign head       = fifo_mem[rd_ptr];
  assign m_vld      = (occ != 2'd0);
  assign pop        = m_vld & bus.m_ready;
  assign head_first = (out_chunk == '0);
  assign head_last  = (out_chunk == LAST_CHK);
  assign final_beat = pop & head_last & ({1'b0, out_neuron} == count - 1'b1);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    case (state)
      IDLE: begin
        if (start && (clamped != '0)) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        // Occupancy after this edge (including the word landing now, minus a
        // beat leaving now) must leave a slot for the word this read returns.
        issue = ({1'b0, occ} + {2'b0, rd_pend}) <= (3'd1 + {2'b0, pop});
        if (issue && (rd_addr == last_addr)) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (final_beat) begin
          state_nxt = loop ? RUN : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      count       <= '0;
      last_addr   <= '0;
      rd_addr     <= '0;
      rd_pend     <= 1'b0;
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      occ         <= 2'd0;
      out_chunk   <= '0;
      out_neuron  <= '0;
      bias_q      <= '0;
      done_q      <= 1'b0;
    end else begin
      done_q  <= final_beat;
      rd_pend <= issue;

      if ((state == IDLE) && start) begin
        count      <= clamped;
        last_addr  <= ADDR_W'(pass_words - 32'd1);
        rd_addr    <= '0;
        out_chunk  <= '0;
        out_neuron <= '0;
        if (clamped == '0) begin
          done_q <= 1'b1;
        end
      end

      // Wrapping at the last address leaves the counter ready for a loop pass.
      if (issue) begin
        rd_addr <= (rd_addr == last_addr) ? '0 : rd_addr + 1'b1;
      end

      if (rd_pend) begin
        fifo_mem[wr_ptr] <= word_t'(bus.mem_rdata);
        wr_ptr           <= ~wr_ptr;
      end

      occ <= occ + {1'b0, rd_pend} - {1'b0, pop};

      if (pop) begin
        rd_ptr <= ~rd_ptr;
        if (head_first) begin
          bias_q <= head.bias;
        end
        if (head_last) begin
          out_chunk  <= '0;
          out_neuron <= final_beat ? '0 : out_neuron + 1'b1;
        end else begin
          out_chunk <= out_chunk + 1'b1;
        end
      end
    end
  end

  assign bus.mem_en    = issue;
  assign bus.mem_addr  = rd_addr;
  assign bus.m_valid   = m_vld;
  assign bus.m_weights = head.weights;
  // Chunk 0 carries the neuron bias; later chunks replay the captured copy.
  assign bus.m_bias    = head_first ? head.bias : bias_q;
  assign bus.m_first   = m_vld & head_first;
  assign bus.m_last    = m_vld & head_last;
  assign bus.m_neuron  = out_neuron;

  assign busy = (state != IDLE) | done_q;
  assign done = done_q;

endmodule

// File: tb/tb_weight_bias_stream_fetcher.sv
`timescale 1ns/1ps
module tb_weight_bias_stream_fetcher;
  localparam int LANES = 4, W_PREC = 8, BIAS_PREC = 32, CHUNKS = 2, M = 16;
  localparam int IDX_W = 4;

  logic             clk = 1'b0;
  logic             clr = 1'b1;
  logic             start = 1'b0;
  logic             loop = 1'b0;
  logic [IDX_W:0]   num_neurons = '0;
  logic             busy, done;

  weight_bias_stream_fetcher_if #(.LANES(LANES), .W_PREC(W_PREC), .BIAS_PREC(BIAS_PREC),
                                  .CHUNKS(CHUNKS), .M(M)) bus ();

  weight_bias_stream_fetcher #(.LANES(LANES), .W_PREC(W_PREC), .BIAS_PREC(BIAS_PREC),
                               .CHUNKS(CHUNKS), .M(M)) dut (
    .clk(clk), .clr(clr), .start(start), .num_neurons(num_neurons), .loop(loop),
    .bus(bus), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] weights;
    logic [31:0] bias;
    logic        first;
    logic        last;
    logic [3:0]  neuron;
  } beat_t;

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, start_cyc = 0;
  int beats_seen = 0, reads_seen = 0, reads_tot = 0, pops_tot = 0;
  int done_cnt = 0, first_vld = -1, last_addr_seen = -1;
  int done_cycles[$];
  beat_t exp_beats[$];
  int exp_addr[$];
  logic prev_stall = 1'b0;
  logic [70:0] prev_snap = '0;
  int ready_mode = 0, phase = 0;
  logic [3:0] tog_pat = 4'b1001;

  function automatic logic [63:0] word(input int k);
    logic [31:0] lo, hi;
    lo = 32'(k) * 32'h0101_0101;
    hi = 32'h1000 + 32'(k);
    return {hi, lo};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // BRAM with one cycle read latency.
  always @(posedge clk or posedge clr) begin
    if (clr) bus.mem_rdata <= '0;
    else if (bus.mem_en) bus.mem_rdata <= word(int'(bus.mem_addr));
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    bus.m_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      phase++;
      case (ready_mode)
        0:       bus.m_ready = 1'b1;
        1:       bus.m_ready = tog_pat[phase % 4];
        default: bus.m_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Observes every cycle away from the active edge.
  always @(negedge clk) begin : monitor
    int idx;
    beat_t cur;
    logic [70:0] snap;
    idx = cyc - start_cyc + 1;
    cur.weights = bus.m_weights;
    cur.bias    = bus.m_bias;
    cur.first   = bus.m_first;
    cur.last    = bus.m_last;
    cur.neuron  = bus.m_neuron;
    snap = {bus.m_valid, cur};
    if (prev_stall) check("stall_hold", snap, prev_snap);
    prev_stall = bus.m_valid & ~bus.m_ready;
    prev_snap  = snap;
    if (bus.mem_en) begin
      reads_seen++;
      reads_tot++;
      last_addr_seen = int'(bus.mem_addr);
      if (exp_addr.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL read_addr: got unexpected read of %0d, required none", bus.mem_addr);
      end else check("read_addr", bus.mem_addr, exp_addr.pop_front());
    end
    if (bus.m_valid && bus.m_ready) begin
      pops_tot++;
      beats_seen++;
      if (exp_beats.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL beat: got unexpected beat %0h, required none", cur);
      end else check("beat", cur, exp_beats.pop_front());
    end
    if (bus.mem_en) check("outstanding_le2", (reads_tot - pops_tot) <= 2, 1);
    if (bus.m_valid && first_vld < 0) first_vld = idx;
    if (done) begin
      done_cnt++;
      done_cycles.push_back(idx);
    end
  end

  // Reference: one pass visits every (neuron, chunk) in order; the bias comes from chunk 0.
  task automatic expect_pass(input int n);
    int c;
    logic [63:0] w, w0;
    beat_t b;
    c = (n > M) ? M : n;
    for (int j = 0; j < c; j++) begin
      w0 = word(j * CHUNKS);
      for (int k = 0; k < CHUNKS; k++) begin
        w = word(j * CHUNKS + k);
        b.weights = w[31:0];
        b.bias    = w0[63:32];
        b.first   = (k == 0);
        b.last    = (k == CHUNKS - 1);
        b.neuron  = 4'(j);
        exp_beats.push_back(b);
        exp_addr.push_back(j * CHUNKS + k);
      end
    end
  endtask

  task automatic clear_stats();
    beats_seen = 0; reads_seen = 0; done_cnt = 0;
    first_vld = -1; last_addr_seen = -1;
    done_cycles.delete();
  endtask

  // Start sampled at edge 0; cycle k is the interval after edge k-1.
  task automatic kick(input int n);
    clear_stats();
    @(posedge clk); #1;
    num_neurons = 5'(n);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    start_cyc = cyc;
    @(negedge clk);
    check("busy_cycle1", busy, 1);
  endtask

  task automatic wait_done(input int k);
    for (int i = 0; i < 4000 && done_cnt < k; i++) @(posedge clk);
    check("done_seen", done_cnt >= k, 1);
  endtask

  task automatic check_end(input int exp_n, input int exp_passes);
    repeat (8) @(posedge clk);
    #1;
    check("beat_count", beats_seen, exp_n);
    check("read_count", reads_seen, exp_n);
    check("done_count", done_cnt, exp_passes);
    check("beats_left", exp_beats.size(), 0);
    check("busy_idle", busy, 0);
  endtask

  function automatic logic [78:0] outvec();
    return {bus.mem_en, bus.mem_addr, bus.m_valid, bus.m_weights, bus.m_bias,
            bus.m_first, bus.m_last, bus.m_neuron, busy, done};
  endfunction

  typedef struct {
    int n; int mode; int exp_beats; int exp_first; int exp_done; int exp_last;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int n;
    tbl[0] = '{3,  0, 6,  3,  9,  5};
    tbl[1] = '{3,  1, 6,  3,  -1, 5};
    tbl[2] = '{0,  0, 0,  -1, 1,  -1};
    tbl[3] = '{20, 0, 32, 3,  35, 31};
    tbl[4] = '{1,  0, 2,  3,  5,  1};
    tbl[5] = '{16, 1, 32, 3,  -1, 31};

    #2;
    check("reset_outputs", outvec(), 0);
    repeat (2) @(posedge clk);
    #2 clr = 1'b0;

    for (int i = 0; i < 6; i++) begin
      ready_mode = tbl[i].mode;
      expect_pass(tbl[i].n);
      kick(tbl[i].n);
      wait_done(1);
      check_end(tbl[i].exp_beats, 1);
      check("first_valid_cycle", first_vld, tbl[i].exp_first);
      if (tbl[i].exp_done >= 0) check("done_cycle", done_cycles[0], tbl[i].exp_done);
      check("last_read_addr", last_addr_seen, tbl[i].exp_last);
    end

    // Loop mode: three passes, loop dropped during the third.
    ready_mode = 0;
    loop = 1'b1;
    repeat (3) expect_pass(2);
    kick(2);
    wait_done(2);
    #1 loop = 1'b0;
    wait_done(3);
    check_end(12, 3);
    check("loop_period_1", done_cycles[1] - done_cycles[0], 6);
    check("loop_period_2", done_cycles[2] - done_cycles[1], 6);

    // Asynchronous clear mid-pass, then a clean restart.
    expect_pass(5);
    kick(5);
    for (int i = 0; i < 200 && beats_seen < 3; i++) @(posedge clk);
    check("reached_beat3", beats_seen >= 3, 1);
    #2 clr = 1'b1;
    #1 check("clr_outputs", outvec(), 0);
    exp_beats.delete();
    exp_addr.delete();
    reads_tot = 0;
    pops_tot = 0;
    @(posedge clk);
    #2 clr = 1'b0;
    repeat (5) @(posedge clk);
    check("no_done_after_clr", done_cnt, 0);
    expect_pass(2);
    kick(2);
    wait_done(1);
    check_end(4, 1);

    // start and num_neurons changes while busy are ignored.
    ready_mode = 1;
    expect_pass(3);
    kick(3);
    repeat (3) @(posedge clk);
    #1;
    num_neurons = 5'd7;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(1);
    check_end(6, 1);

    // Random neuron counts under random backpressure.
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(0, 20);
      ready_mode = 2;
      expect_pass(n);
      kick(n);
      wait_done(1);
      check_end(((n > M) ? M : n) * CHUNKS, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end
endmodule
